ex_stage: RTL and testbench

- Execute stage directly downstream of the decode/execute pipeline register.
- Consumes the two registered operands and the 4-bit ALU function code, and performs the operation.
- Registers result, zero flag and valid into the execute/memory boundary.
- Single-cycle ops have 1-cycle latency. MUL/DIVU/REMU run a 32-iteration sequential engine and stall upstream via stall_ex.

---
 rtl/ex_stage.sv | 188 ++++++++++++++++++
 tb/tb_ex_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU ops plus a 32-iteration shift-add multiplier
// and restoring divider that stall upstream while busy.
module ex_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic              clk_ex,
    input  logic              reset_ex,
    input  logic              flush_ex,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [3:0]        alu_func,
    output logic              stall_ex,
    output logic              out_valid,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    localparam int unsigned SH_W = $clog2(DATA_W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    localparam logic [3:0] F_AND  = 4'b0000;
    localparam logic [3:0] F_OR   = 4'b0001;
    localparam logic [3:0] F_ADD  = 4'b0010;
    localparam logic [3:0] F_SLL  = 4'b0011;
    localparam logic [3:0] F_SRL  = 4'b0100;
    localparam logic [3:0] F_SRA  = 4'b0101;
    localparam logic [3:0] F_SUB  = 4'b0110;
    localparam logic [3:0] F_SLT  = 4'b0111;
    localparam logic [3:0] F_MUL  = 4'b1000;
    localparam logic [3:0] F_DIVU = 4'b1001;
    localparam logic [3:0] F_REMU = 4'b1010;
    localparam logic [3:0] F_NOR  = 4'b1100;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        func_q, func_d;
    logic [DATA_W-1:0] a_q, a_d;      // multiplicand / dividend-then-quotient
    logic [DATA_W-1:0] b_q, b_d;      // multiplier / divisor
    logic [DATA_W-1:0] acc_q, acc_d;  // partial product / partial remainder
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;
    logic              out_valid_q, out_valid_d;

    logic [DATA_W-1:0] alu_c;
    logic [SH_W-1:0]   shamt;
    logic [DATA_W-1:0] mul_sum;
    logic [DATA_W:0]   rem_sh;
    logic [DATA_W:0]   rem_diff;
    logic              rem_ge;
    logic [DATA_W-1:0] rem_nxt;
    logic [DATA_W-1:0] quo_nxt;
    logic              last_iter;

    assign stall_ex  = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;

    assign shamt = op_b[SH_W-1:0];

    // Single-cycle operations, evaluated straight from the request inputs
    always_comb begin
        alu_c = '0;
        case (alu_func)
            F_AND:   alu_c = op_a & op_b;
            F_OR:    alu_c = op_a | op_b;
            F_ADD:   alu_c = op_a + op_b;
            F_SUB:   alu_c = op_a - op_b;
            F_SLT:   alu_c = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            F_NOR:   alu_c = ~(op_a | op_b);
            F_SLL:   alu_c = op_a << shamt;
            F_SRL:   alu_c = op_a >> shamt;
            F_SRA:   alu_c = DATA_W'($signed(op_a) >>> shamt);
            default: alu_c = '0;
        endcase
    end

    // One iteration of each engine
    always_comb begin
        mul_sum   = acc_q + (b_q[0] ? a_q : '0);
        rem_sh    = {acc_q, a_q[DATA_W-1]};
        rem_diff  = rem_sh - {1'b0, b_q};
        rem_ge    = ~rem_diff[DATA_W];
        rem_nxt   = rem_ge ? rem_diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
        quo_nxt   = {a_q[DATA_W-2:0], rem_ge};
        last_iter = (cnt_q == CNT_W'(DATA_W - 1));
    end

    // Next-state and datapath control
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        func_d      = func_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        result_d    = result_q;
        zero_d      = zero_q;
        out_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (alu_func == F_MUL || alu_func == F_DIVU || alu_func == F_REMU) begin
                        state_d = (alu_func == F_MUL) ? S_MUL : S_DIV;
                        func_d  = alu_func;
                        a_d     = op_a;
                        b_d     = op_b;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        result_d    = alu_c;
                        zero_d      = (alu_c == '0);
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_sum;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                    result_d    = mul_sum;
                    zero_d      = (mul_sum == '0);
                    out_valid_d = 1'b1;
                end
            end
            S_DIV: begin
                acc_d = rem_nxt;
                a_d   = quo_nxt;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                    result_d    = (func_q == F_REMU) ? rem_nxt : quo_nxt;
                    zero_d      = (((func_q == F_REMU) ? rem_nxt : quo_nxt) == '0);
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Flush discards the op in flight and any request this cycle, keeping result/zero
        if (flush_ex) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            result_d    = result_q;
            zero_d      = zero_q;
        end
    end

    always_ff @(posedge clk_ex) begin
        if (reset_ex) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            func_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            func_q      <= func_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: table of single-cycle vectors plus hand-written
// multi-cycle, flush and reset sequences.
module tb_ex_stage;

    logic        clk_ex = 1'b0;
    logic        reset_ex;
    logic        flush_ex;
    logic        in_valid;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  alu_func;
    logic        stall_ex;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0]  func;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    ex_stage #(.DATA_W(32), .CNT_W(6)) dut (
        .clk_ex    (clk_ex),
        .reset_ex  (reset_ex),
        .flush_ex  (flush_ex),
        .in_valid  (in_valid),
        .op_a      (op_a),
        .op_b      (op_b),
        .alu_func  (alu_func),
        .stall_ex  (stall_ex),
        .out_valid (out_valid),
        .result    (result),
        .zero      (zero)
    );

    always #5 clk_ex = ~clk_ex;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance one edge and settle; inputs are driven and outputs sampled 1ns after the edge
    task automatic step();
        @(posedge clk_ex);
        #1;
    endtask

    // Start a multi-cycle op, then measure completion latency and stall cycles
    task automatic run_multi(input string name, input logic [3:0] f, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp);
        int n;
        int stall_cnt;
        in_valid = 1'b1; alu_func = f; op_a = a; op_b = b;
        step();
        chk({name, "_accept_ov"}, 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        n = 0;
        stall_cnt = stall_ex ? 1 : 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
            if (stall_ex) stall_cnt++;
        end
        chk({name, "_latency"}, 32'(n), 32'd32);
        chk({name, "_stall_cycles"}, 32'(stall_cnt), 32'd32);
        chk({name, "_result"}, result, exp);
        chk({name, "_zero"}, 32'(zero), 32'(exp == 32'd0));
        step();
        chk({name, "_ov_pulse"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int n;
        int stall_cnt;
        logic saw_ov;
        logic [31:0] prior;

        vecs[0]  = '{4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0};
        vecs[1]  = '{4'b0110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1};
        vecs[2]  = '{4'b0101, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0};
        vecs[3]  = '{4'b0000, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000, 1'b0};
        vecs[4]  = '{4'b0001, 32'h0000_00F0, 32'h0000_0F00, 32'h0000_0FF0, 1'b0};
        vecs[5]  = '{4'b1100, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
        vecs[6]  = '{4'b0111, 32'h0000_0005, 32'hFFFF_FFFD, 32'h0000_0000, 1'b1};
        vecs[7]  = '{4'b0111, 32'hFFFF_FFFD, 32'h0000_0005, 32'h0000_0001, 1'b0};
        vecs[8]  = '{4'b0011, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0};
        vecs[9]  = '{4'b0011, 32'h0000_0003, 32'h0000_0025, 32'h0000_0060, 1'b0};
        vecs[10] = '{4'b0100, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0};
        vecs[11] = '{4'b0110, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0};
        vecs[12] = '{4'b0010, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b0};
        vecs[13] = '{4'b1111, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 1'b1};
        vecs[14] = '{4'b1011, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 1'b1};

        reset_ex = 1'b1; flush_ex = 1'b0; in_valid = 1'b0;
        op_a = '0; op_b = '0; alu_func = '0;
        step();
        step();
        reset_ex = 1'b0;
        chk("rst_result", result, 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_stall", 32'(stall_ex), 32'd0);

        // Back-to-back single-cycle ops
        for (int i = 0; i < NV; i++) begin
            in_valid = 1'b1; alu_func = vecs[i].func; op_a = vecs[i].a; op_b = vecs[i].b;
            step();
            chk($sformatf("vec%0d_result", i), result, vecs[i].res);
            chk($sformatf("vec%0d_zero", i), 32'(zero), 32'(vecs[i].z));
            chk($sformatf("vec%0d_ov", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_stall", i), 32'(stall_ex), 32'd0);
        end
        in_valid = 1'b0;
        step();
        chk("idle_ov", 32'(out_valid), 32'd0);
        chk("idle_hold", result, 32'd0);

        // MUL with a held ADD request behind it
        in_valid = 1'b1; alu_func = 4'b1000; op_a = 32'd7; op_b = 32'd6;
        step();
        chk("mul7x6_accept_ov", 32'(out_valid), 32'd0);
        alu_func = 4'b0010; op_a = 32'd3; op_b = 32'd4;
        n = 0;
        stall_cnt = stall_ex ? 1 : 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
            if (stall_ex) stall_cnt++;
        end
        chk("mul7x6_latency", 32'(n), 32'd32);
        chk("mul7x6_stall_cycles", 32'(stall_cnt), 32'd32);
        chk("mul7x6_result", result, 32'h2A);
        step();
        in_valid = 1'b0;
        chk("held_add_result", result, 32'd7);
        chk("held_add_ov", 32'(out_valid), 32'd1);
        step();
        chk("held_add_pulse", 32'(out_valid), 32'd0);

        run_multi("mul_ff", 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        run_multi("mul_big", 4'b1000, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F);
        run_multi("divu_100_7", 4'b1001, 32'd100, 32'd7, 32'hE);
        run_multi("remu_100_7", 4'b1010, 32'd100, 32'd7, 32'h2);
        run_multi("divu_by0", 4'b1001, 32'h1234, 32'd0, 32'hFFFF_FFFF);
        run_multi("remu_by0", 4'b1010, 32'h1234, 32'd0, 32'h1234);
        run_multi("divu_small", 4'b1001, 32'd7, 32'd100, 32'h0);
        run_multi("divu_max", 4'b1001, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF);

        // Flush mid-MUL: op discarded, result kept
        in_valid = 1'b1; alu_func = 4'b0010; op_a = 32'h55; op_b = 32'h0;
        step();
        prior = 32'h55;
        chk("pre_flush_result", result, prior);
        alu_func = 4'b1000; op_a = 32'd9; op_b = 32'd9;
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 9; c++) step();
        flush_ex = 1'b1;
        step();
        flush_ex = 1'b0;
        chk("flush_stall", 32'(stall_ex), 32'd0);
        chk("flush_ov", 32'(out_valid), 32'd0);
        chk("flush_result", result, prior);
        saw_ov = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (out_valid || stall_ex) saw_ov = 1'b1;
        end
        chk("flush_no_late_ov", 32'(saw_ov), 32'd0);
        chk("flush_result_hold", result, prior);

        // Reset mid-DIVU, then an SLT
        in_valid = 1'b1; alu_func = 4'b1001; op_a = 32'd1000; op_b = 32'd3;
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 19; c++) step();
        chk("pre_reset_stall", 32'(stall_ex), 32'd1);
        reset_ex = 1'b1;
        step();
        reset_ex = 1'b0;
        chk("midrst_result", result, 32'd0);
        chk("midrst_zero", 32'(zero), 32'd1);
        chk("midrst_ov", 32'(out_valid), 32'd0);
        chk("midrst_stall", 32'(stall_ex), 32'd0);
        in_valid = 1'b1; alu_func = 4'b0111; op_a = 32'hFFFF_FFFF; op_b = 32'd1;
        step();
        in_valid = 1'b0;
        chk("slt_after_rst", result, 32'd1);
        chk("slt_after_rst_ov", 32'(out_valid), 32'd1);
        chk("slt_after_rst_zero", 32'(zero), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
